// File: rtl/output_port_fifo_if.sv
// Write-port / display-side signal bundle for output_port_fifo.
// The processor side drives master; the FIFO implements slave.
interface output_port_fifo_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] Wdata;
  logic              WE;
  logic [WORD_W-1:0] digits;
  logic              valid;
  logic              full;
  logic              empty;
  logic              overflow;

  modport master (
    output Wdata, WE,
    input  digits, valid, full, empty, overflow
  );

  modport slave (
    input  Wdata, WE,
    output digits, valid, full, empty, overflow
  );
endinterface

// File: rtl/output_port_fifo.sv
// Buffered output port: queues processor writes in a small FIFO and shows
// each word on digits for at least HOLD_CYCLES clocks.
module output_port_fifo #(
  parameter int WORD_W      = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  output_port_fifo_if.slave   bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [HOLD_W-1:0] r_hold;
  logic [WORD_W-1:0] r_digits;
  logic              r_valid;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Status comes only from registered count, so WE never reaches full/empty.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.WE && !w_full;
  assign w_drop  = bus.WE && w_full;
  assign w_pop   = !w_empty && (r_hold == '0);

  // Storage holds data only; stale entries are unreachable once count is cleared.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.Wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_hold     <= '0;
      r_digits   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_drop) r_overflow <= 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_digits <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_hold   <= HOLD_W'(HOLD_CYCLES - 1);
        r_valid  <= 1'b1;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
    end
  end

  assign bus.digits   = r_digits;
  assign bus.valid    = r_valid;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.overflow = r_overflow;

endmodule

// File: doc/output_port_fifo.md
# output_port_fifo

Parametrised successor to the basic processor's output register. It accepts words from the processor's write port into a DEPTH-entry FIFO and presents them one at a time on `digits`. Each presented word is held for at least HOLD_CYCLES clocks, so a slow display or observer sees every word even when the processor writes in bursts. The block sits between the processor's output write strobe and the display driver, and returns a `full` status so software or the controller can throttle writes.

## Interface
- WORD_W, 8, width of data words and of `digits`
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- HOLD_CYCLES, 4, minimum clocks each word stays on `digits`; ≥ 1
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- Wdata  input  WORD_W  word to output
- WE  input  1  write strobe, one word per cycle while high
- digits  output  WORD_W  currently displayed word (registered)
- valid  output  1  high once any word has been displayed since reset
- full  output  1  FIFO holds DEPTH words; writes this cycle are dropped
- empty  output  1  FIFO holds 0 words
- overflow  output  1  sticky; set when a write is dropped

## Operation
- Storage:
  - DEPTH × WORD_W array with read and write pointers of log2(DEPTH) bits.
  - Pointers wrap from DEPTH-1 to 0.
  - Occupancy counter `count` of log2(DEPTH)+1 bits, range 0..DEPTH.
- `full` = (count == DEPTH); `empty` = (count == 0). Both are decoded from registered `count` only, with no combinational path from WE.
- Push: WE && !full. Wdata is written at the write pointer, the pointer advances, and count increments.
- Dropped write: WE && full. Storage is unchanged and `overflow` <= 1. `overflow` clears only on reset.
- Hold counter `hold_cnt` ranges 0..HOLD_CYCLES-1.
  - Decrements each cycle while nonzero.
  - When it is 0, the display is released.
- Pop: !empty && hold_cnt == 0. On a pop:
  - `digits` <= entry at the read pointer;
  - the read pointer advances and count decrements;
  - `hold_cnt` <= HOLD_CYCLES-1;
  - `valid` <= 1.
- After release with the FIFO empty, `digits` keeps the last word indefinitely.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- `full` is evaluated before the edge. A write while full is dropped even if a pop occurs on the same edge; there is no same-cycle slot reuse.
- No bypass: a word written into an empty FIFO is stored first and popped on a later edge.
- Reset (asynchronous, any time, including mid-burst or mid-hold):
  - digits = 0, valid = 0, full = 0, empty = 1, overflow = 0;
  - count = 0, pointers = 0, hold_cnt = 0.
  - FIFO contents are discarded and must never appear on `digits` after reset is released.

## Timing
- Write latency with an idle display: WE sampled at edge k → pop at edge k+1 → `digits` updated after edge k+1.
- A popped word is stable on `digits` for exactly HOLD_CYCLES cycles if another word is waiting, otherwise until the next pop.
- Sustained throughput is 1 word per HOLD_CYCLES clocks. With HOLD_CYCLES = 1 this is 1 word/clock, and `full` never asserts under continuous single writes.
- `full`, `empty` and `overflow` change only on clock edges or on reset assertion.

## Test plan
All scenarios use defaults (WORD_W=8, DEPTH=4, HOLD_CYCLES=4) unless stated.
1. Reset: assert reset mid-cycle with no clock edge → immediately digits=0x00, valid=0, empty=1, full=0, overflow=0.
2. Single write: WE=1, Wdata=0x3C for one cycle at edge 1 → digits=0x3C and valid=1 after edge 2; empty=1 after edge 2.
3. Burst with overflow: WE high for 6 consecutive edges with 0x01..0x06 →
   - 0x01 appears after edge 2;
   - full=1 after edge 5;
   - 0x06 is dropped and overflow=1 after edge 6;
   - digits shows 0x01, 0x02, 0x03, 0x04, 0x05, each for exactly 4 cycles; 0x06 never appears.
4. Pointer wrap: write 0x10..0x19 (10 words), one write every 4 cycles → all 10 words appear in order, overflow stays 0, and both pointers wrap at least twice.
5. Reset mid-operation: with 3 words queued and hold_cnt=2, pulse reset → outputs return to reset values immediately; after release and 10 idle cycles, digits stays 0x00 and valid=0.
6. HOLD_CYCLES=1: WE high for 8 edges with 0xA0..0xA7 → digits steps 0xA0..0xA7 on consecutive edges, 1 cycle after each write; full stays 0 and overflow stays 0.
